// File: rtl/key_event_encoder_if.sv
// Button-event bundle between the raw keypad and the mode controller.
// The master drives the clean events from the raw keys; the slave supplies the raw keys and consumes the events.
interface key_event_encoder_if;
  logic       raw_menu;
  logic [2:0] raw_speed;
  logic       raw_clean;
  logic       menu_btn;
  logic [2:0] speed_btn;
  logic       clean_btn;
  logic       conflict;
  logic       key_held;

  modport master (
    input  raw_menu, raw_speed, raw_clean,
    output menu_btn, speed_btn, clean_btn, conflict, key_held
  );

  modport slave (
    output raw_menu, raw_speed, raw_clean,
    input  menu_btn, speed_btn, clean_btn, conflict, key_held
  );
endinterface

// File: rtl/key_event_encoder.sv
// Synchronises and debounces the range-hood buttons and turns each press into a legal one-cycle event.
// Channel order in the internal vectors: bit0 menu, bits1..3 speed gear 1..3, bit4 clean.
module key_event_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  key_event_encoder_if.master  kif
);

  localparam int                NCH      = 5;
  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] raw_vec;
  logic [NCH-1:0] sync0;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] stable;
  logic [NCH-1:0] stable_last;
  logic [19:0]    cnt [NCH];
  logic [NCH-1:0] press;

  logic       menu_nxt;
  logic [2:0] speed_nxt;
  logic       clean_nxt;
  logic       conflict_nxt;
  logic [2:0] sp_press;
  logic [2:0] sp_stable;

  assign raw_vec = {kif.raw_clean, kif.raw_speed, kif.raw_menu};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0       <= '0;
      sync1       <= '0;
      stable      <= '0;
      stable_last <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      sync0       <= raw_vec;
      sync1       <= sync0;
      stable_last <= stable;
      // A single matching cycle restarts the count, so only an unbroken run flips stable.
      for (int i = 0; i < NCH; i++) begin
        if (sync1[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 20'd1;
        end
      end
    end
  end

  assign press     = stable & ~stable_last;
  assign sp_press  = press[3:1];
  assign sp_stable = stable[3:1];

  always_comb begin
    menu_nxt     = press[0];
    speed_nxt    = 3'b000;
    clean_nxt    = 1'b0;
    conflict_nxt = 1'b0;
    if (sp_press != 3'b000) begin
      // Multiple gears at once, or a gear while another is held, are ambiguous and dropped.
      if ((sp_press & (sp_press - 3'd1)) != 3'b000) begin
        conflict_nxt = 1'b1;
      end else if ((sp_stable & ~sp_press) != 3'b000) begin
        conflict_nxt = 1'b1;
      end else begin
        speed_nxt = sp_press;
      end
      if (press[4]) conflict_nxt = 1'b1;
    end else if (press[4]) begin
      clean_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kif.menu_btn  <= 1'b0;
      kif.speed_btn <= 3'b000;
      kif.clean_btn <= 1'b0;
      kif.conflict  <= 1'b0;
      kif.key_held  <= 1'b0;
    end else begin
      kif.menu_btn  <= menu_nxt;
      kif.speed_btn <= speed_nxt;
      kif.clean_btn <= clean_nxt;
      kif.conflict  <= conflict_nxt;
      kif.key_held  <= |stable;
    end
  end

endmodule

// File: tb/tb_key_event_encoder.sv
// Scenario bench for key_event_encoder with DEBOUNCE_CYCLES=4; expected events are queued with their due cycle.
module tb_key_event_encoder;

  localparam int D   = 4;
  localparam int LAT = D + 3;  // from drive (before sampling edge e0) to the negedge after edge e0+D+2

  typedef struct {
    int         cyc;
    logic       menu;
    logic [2:0] speed;
    logic       clean;
    logic       conflict;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_assert;
  int   n_fail;
  ev_t  sb[$];

  key_event_encoder_if kif ();

  key_event_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Every nonzero event output must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    if (!reset && (kif.menu_btn || kif.speed_btn != 3'b000 || kif.clean_btn || kif.conflict)) begin
      n_assert = n_assert + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_event cyc=%0d got menu=%b speed=%b clean=%b conflict=%b, expected no event",
                 cyc, kif.menu_btn, kif.speed_btn, kif.clean_btn, kif.conflict);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (cyc !== e.cyc || kif.menu_btn !== e.menu || kif.speed_btn !== e.speed ||
            kif.clean_btn !== e.clean || kif.conflict !== e.conflict) begin
          n_fail = n_fail + 1;
          $display("FAIL event cyc=%0d menu=%b speed=%b clean=%b conflict=%b, expected cyc=%0d menu=%b speed=%b clean=%b conflict=%b",
                   cyc, kif.menu_btn, kif.speed_btn, kif.clean_btn, kif.conflict,
                   e.cyc, e.menu, e.speed, e.clean, e.conflict);
        end
      end
    end
  end

  task automatic push_ev(input int due, input logic m, input logic [2:0] s, input logic c, input logic cf);
    ev_t e;
    e.cyc = due; e.menu = m; e.speed = s; e.clean = c; e.conflict = cf;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    idle(12);
    n_assert = n_assert + 1;
    if (sb.size() !== 0) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_missing_events pending=%0d, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    kif.raw_menu = 1'b0; kif.raw_speed = 3'b000; kif.raw_clean = 1'b0;
    idle(3);
    n_assert = n_assert + 1;
    if ({kif.menu_btn, kif.speed_btn, kif.clean_btn, kif.conflict, kif.key_held} !== 7'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_outputs got %b, expected 0000000",
               {kif.menu_btn, kif.speed_btn, kif.clean_btn, kif.conflict, kif.key_held});
    end
    reset = 1'b0;
    idle(10);
    n_assert = n_assert + 1;
    if ({kif.menu_btn, kif.speed_btn, kif.clean_btn, kif.conflict, kif.key_held} !== 7'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL idle_outputs got %b, expected 0000000",
               {kif.menu_btn, kif.speed_btn, kif.clean_btn, kif.conflict, kif.key_held});
    end
  endtask

  task automatic test_single_speed();
    push_ev(cyc + LAT, 1'b0, 3'b001, 1'b0, 1'b0);
    kif.raw_speed = 3'b001;
    idle(3);
    n_assert = n_assert + 1;
    if (kif.key_held !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL single_key_held_early got %b, expected 0", kif.key_held);
    end
    idle(17);
    n_assert = n_assert + 1;
    if (kif.key_held !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL single_key_held got %b, expected 1", kif.key_held);
    end
    kif.raw_speed = 3'b000;
    idle(10);
    n_assert = n_assert + 1;
    if (kif.key_held !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL single_key_released got %b, expected 0", kif.key_held);
    end
    drain("single_speed");
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    pat = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) push_ev(cyc + LAT, 1'b1, 3'b000, 1'b0, 1'b0);
      kif.raw_menu = pat[i];
      @(negedge clk);
    end
    idle(14);
    kif.raw_menu = 1'b0;
    drain("bounce");
  endtask

  task automatic test_multi_speed();
    push_ev(cyc + LAT, 1'b0, 3'b000, 1'b0, 1'b1);
    kif.raw_speed = 3'b011;
    idle(14);
    kif.raw_speed = 3'b000;
    drain("multi_speed");
    push_ev(cyc + LAT, 1'b0, 3'b100, 1'b0, 1'b0);
    kif.raw_speed = 3'b100;
    idle(14);
    kif.raw_speed = 3'b000;
    drain("gear3");
  endtask

  task automatic test_held_conflict();
    int k;
    push_ev(cyc + LAT, 1'b0, 3'b001, 1'b0, 1'b0);
    kif.raw_speed = 3'b001;
    k = 0;
    while (kif.key_held !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_assert = n_assert + 1;
    if (kif.key_held !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL held_wait_key_held got %b after %0d cycles, expected 1", kif.key_held, k);
    end
    push_ev(cyc + LAT, 1'b0, 3'b000, 1'b0, 1'b1);
    kif.raw_speed = 3'b011;
    idle(14);
    kif.raw_speed = 3'b000;
    drain("held_conflict");
  endtask

  task automatic test_combo();
    push_ev(cyc + LAT, 1'b1, 3'b010, 1'b0, 1'b1);
    kif.raw_menu = 1'b1; kif.raw_speed = 3'b010; kif.raw_clean = 1'b1;
    idle(14);
    kif.raw_menu = 1'b0; kif.raw_speed = 3'b000; kif.raw_clean = 1'b0;
    drain("combo");
  endtask

  task automatic test_reset_mid();
    kif.raw_clean = 1'b1;
    repeat (4) @(posedge clk);  // counter reaches 2
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_assert = n_assert + 1;
      if ({kif.menu_btn, kif.speed_btn, kif.clean_btn, kif.conflict, kif.key_held} !== 7'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL reset_mid_outputs got %b, expected 0000000",
                 {kif.menu_btn, kif.speed_btn, kif.clean_btn, kif.conflict, kif.key_held});
      end
    end
    push_ev(cyc + LAT, 1'b0, 3'b000, 1'b1, 1'b0);
    reset = 1'b0;
    idle(14);
    kif.raw_clean = 1'b0;
    drain("reset_mid");
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    kif.raw_menu = 1'b0; kif.raw_speed = 3'b000; kif.raw_clean = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_speed();
    test_bounce();
    test_multi_speed();
    test_held_conflict();
    test_combo();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
